// File: rtl/port_allocator_pkg.sv
// port_allocator_pkg: flit types, port indices and FSM encoding shared by the allocator.
// Consumed by port_allocator and rr_pick5.
package port_allocator_pkg;
    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;
    localparam logic [2:0] L = 3'd0;
    localparam logic [2:0] N = 3'd1;
    localparam logic [2:0] E = 3'd2;
    localparam logic [2:0] W = 3'd3;
    localparam logic [2:0] S = 3'd4;

    typedef enum logic {IDLE, LOCK} state_t;

    function automatic logic [2:0] oh2idx(input logic [4:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 5; i++)
            if (oh[i]) oh2idx = 3'(i);
    endfunction
endpackage

// File: rtl/port_allocator_rr_pick5.sv
// rr_pick5: combinational round-robin pick of one candidate, searching from (ptr+1) mod 5.
module rr_pick5
    import port_allocator_pkg::*;
(
    input  logic [4:0] cand,
    input  logic [2:0] ptr,
    output logic [4:0] win
);
    logic [2:0] idx;

    // Walk from lowest to highest priority so the nearest candidate overwrites the rest.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 5; k >= 1; k--) begin
            idx = 3'((32'(ptr) + k) % 5);
            if (cand[idx]) win = 5'(1) << idx;
        end
    end
endmodule

// File: rtl/port_allocator.sv
// port_allocator: wormhole output-port allocator, round-robin over five input ports.
// Optional stall watchdog with pkt_err under macro PORT_ALLOC_TIMEOUT_EN.
module port_allocator
    import port_allocator_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         req,
    input  logic [14:0]        flit_id,
    input  logic [5*LEN_W-1:0] length,
    input  logic               down_ready,
    output logic [4:0]         grant,
    output logic               busy
`ifdef PORT_ALLOC_TIMEOUT_EN
    ,
    output logic               pkt_err
`endif
);
    state_t state, state_n;
    logic [2:0] win, rr_ptr, pidx;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] lens [5];
    logic [2:0] ftype [5];
    logic [4:0] cand, pick;
    logic go, last, abort;

    for (genvar i = 0; i < 5; i++) begin : g_port
        assign lens[i]  = length[LEN_W*i +: LEN_W];
        assign ftype[i] = flit_id[3*i +: 3];
        assign cand[i]  = req[i] && ftype[i] == HEADER;
    end

    rr_pick5 u_pick (.cand(cand), .ptr(rr_ptr), .win(pick));

    assign pidx  = oh2idx(pick);
    assign go    = !rst && state == LOCK && req[win] && down_ready;
    assign grant = go ? 5'(1) << win : '0;
    assign busy  = state == LOCK;
    assign last  = cnt == LEN_W'(1) || ftype[win] == TAIL;

`ifdef PORT_ALLOC_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall;

    assign abort = state == LOCK && !go && stall == SW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        stall   <= (rst || state_n != LOCK || go) ? '0 : stall + 1'b1;
        pkt_err <= !rst && abort;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (|cand ? LOCK : IDLE)
                                  : ((go && last) || abort ? IDLE : LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 3'd4;
            win    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |cand) begin
                win <= pidx;
                cnt <= (lens[pidx] == '0) ? LEN_W'(1) : lens[pidx];
            end else if (go && cnt > LEN_W'(1)) begin
                cnt <= cnt - 1'b1;
            end
            if (state == LOCK && state_n == IDLE) rr_ptr <= win;
        end
    end
endmodule

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 Parameter LEN_W, 12, width of the packet-length field and the flit counter.
REQ-002 Parameter TIMEOUT, 255, stall-cycle limit for the watchdog (REQ-021).
REQ-003 clk  input  1  rising-edge clock; one clock; all state in this domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  5  per-input-port request from flow control; bit order [0]=L [1]=N [2]=E [3]=W [4]=S.
REQ-006 flit_id  input  15  3-bit flit type per port, packed in the same order (port i at [3i+2:3i]).
REQ-007 length  input  60  12-bit packet length per port, in flits including the header, packed in the same order.
REQ-008 down_ready  input  1  downstream clear-to-send (DCTS) for this output port.
REQ-009 grant  output  5  one-hot per-cycle read enable and crossbar select; all-zero when no transfer happens.
REQ-010 busy  output  1  high while a packet owns the port (state LOCK).
REQ-011 pkt_err  output  1  one-cycle pulse on watchdog abort; present only with the macro in REQ-024.

Function
REQ-012 FSM states are IDLE and LOCK.
REQ-013 IDLE: the candidates are ports with req=1 and flit_id=HEADER (3'b001). The winner is chosen round-robin, starting at port (rr_ptr+1) mod 5.
REQ-014 IDLE with at least one candidate: the FSM registers the winner, loads cnt=length[winner], and moves to LOCK. grant stays 0 in that cycle (one-cycle allocation latency).
REQ-015 If the loaded length is 0, it is treated as 1.
REQ-016 LOCK: grant[winner] = req[winner] & down_ready, combinational. All other grant bits are 0.
REQ-017 LOCK: each cycle grant is nonzero, cnt decrements by 1. No decrement happens when down_ready=0 or req=0.
REQ-018 LOCK release: when the granted flit has cnt==1 or flit_id=TAIL (3'b100), the FSM moves to IDLE at the next edge and sets rr_ptr=winner. A TAIL flit wins over a cnt>1.
REQ-019 IDLE is always entered for at least one cycle between packets (one bubble), even when requests are pending.
REQ-020 Requests from non-owner ports during LOCK are ignored. They are not queued, and fairness comes only from rr_ptr.
REQ-021 grant is never asserted when down_ready=0. A cycle with down_ready=0 and req=1 counts as a stall cycle.
REQ-022 cnt is LEN_W bits and never wraps below 1 while in LOCK.

Reset
REQ-023 When rst=1 at an edge: state=IDLE, grant=0 (combinationally gated while rst=1), busy=0, pkt_err=0, rr_ptr=4 (so L wins first), cnt=0. Asserting reset mid-packet abandons the packet with no further grant.

Configuration
REQ-024 Macro PORT_ALLOC_TIMEOUT_EN.
- Defined: a stall counter counts consecutive LOCK cycles with no grant. On reaching TIMEOUT, the FSM returns to IDLE, rr_ptr=winner, and pkt_err pulses for 1 cycle. The counter clears on any grant or on leaving LOCK.
- Undefined: there is no stall counter, the pkt_err port is absent, and LOCK holds indefinitely.

Structure
REQ-025 The shared include file holds the flit-type constants (HEADER 3'b001, BODY 3'b010, TAIL 3'b100), the port index constants L..S=0..4, and the FSM state encodings.
REQ-026 A single sub-module, rr_pick5, takes a 5-bit candidate vector and a 3-bit pointer and returns a one-hot winner, combinationally. It is instantiated once.

Verification
REQ-027 Reset, then E header with length=3 and down_ready=1 held -> grant=00000 for 1 cycle, then 00100 for 3 cycles, then IDLE with busy=0.
REQ-028 After reset, L/N/E/W/S headers all requested together, each length 1 -> winners in order L,N,E,W,S, with one bubble between each.
REQ-029 N header length=4, down_ready low on the 2nd data cycle -> grant=0 that cycle, cnt holds, and 4 grants in total.
REQ-030 W header length=8, W presents TAIL on its 3rd granted flit -> release after 3 grants and rr_ptr=3.
REQ-031 S header length=0 -> exactly 1 grant, then IDLE.
REQ-032 With PORT_ALLOC_TIMEOUT_EN and TIMEOUT=4, L locked, down_ready=0 -> pkt_err pulses after 4 stall cycles, then IDLE; a rst pulse mid-LOCK drops grant in the same cycle.
